// File: rtl/queue_dispatcher.sv
// Read-side dispatcher for a per-port core-ID queue: pops the head entry and
// grants it memory access until its budget, idle timeout or a preemption ends the grant.
module queue_dispatcher #(
  parameter int DATA_SIZE     = 8,
  parameter int REGISTER_SIZE = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REGISTER_SIZE-1:0] budget,
  input  logic [REGISTER_SIZE-1:0] idle_limit,
  input  logic [DATA_SIZE-1:0]     q_value,
  input  logic                     q_empty,
  output logic                     q_consumed,
  input  logic                     txn_done,
  input  logic                     preempt,
  output logic [DATA_SIZE-1:0]     grant_id,
  output logic                     grant_valid,
  output logic                     busy,
  output logic [1:0]               exit_reason,
  output logic [REGISTER_SIZE-1:0] grants_issued
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [REGISTER_SIZE-1:0] REG_MAX  = {REGISTER_SIZE{1'b1}};
  localparam logic [REGISTER_SIZE-1:0] REG_ONE  = {{(REGISTER_SIZE-1){1'b0}}, 1'b1};
  localparam logic [REGISTER_SIZE-1:0] REG_ZERO = {REGISTER_SIZE{1'b0}};

  state_t                   state_r, state_s;
  logic [DATA_SIZE-1:0]     grant_id_r, grant_id_s;
  logic                     grant_valid_r, grant_valid_s;
  logic                     q_consumed_r, q_consumed_s;
  logic                     busy_r, busy_s;
  logic [1:0]               exit_reason_r, exit_reason_s;
  logic [REGISTER_SIZE-1:0] grants_issued_r, grants_issued_s;
  logic [REGISTER_SIZE-1:0] txn_cnt_r, txn_cnt_s;
  logic [REGISTER_SIZE-1:0] idle_cnt_r, idle_cnt_s;
  logic [REGISTER_SIZE-1:0] budget_r, budget_s;
  logic [REGISTER_SIZE-1:0] idle_r, idle_s;
  logic [1:0]               exit_code_s;

  // Sums are one bit wider so an all-ones counter plus one cannot wrap below the limit.
  logic [REGISTER_SIZE:0] txn_sum_s;
  logic [REGISTER_SIZE:0] idle_sum_s;
  logic                   budget_hit_s;
  logic                   idle_hit_s;

  assign txn_sum_s    = {1'b0, txn_cnt_r} + {{REGISTER_SIZE{1'b0}}, txn_done};
  assign idle_sum_s   = {1'b0, idle_cnt_r} + {{REGISTER_SIZE{1'b0}}, 1'b1};
  assign budget_hit_s = (budget_r != REG_ZERO) && (txn_sum_s >= {1'b0, budget_r});
  assign idle_hit_s   = (idle_r != REG_ZERO) && !txn_done && (idle_sum_s >= {1'b0, idle_r});

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus next value of every registered output and counter.
  always_comb begin
    state_s         = state_r;
    grant_id_s      = grant_id_r;
    grant_valid_s   = grant_valid_r;
    q_consumed_s    = 1'b0;
    busy_s          = busy_r;
    exit_reason_s   = exit_reason_r;
    grants_issued_s = grants_issued_r;
    txn_cnt_s       = txn_cnt_r;
    idle_cnt_s      = idle_cnt_r;
    budget_s        = budget_r;
    idle_s          = idle_r;
    exit_code_s     = 2'd0;
    case (state_r)
      ST_IDLE: begin
        if (!q_empty) begin
          state_s       = ST_GRANT;
          grant_id_s    = q_value;
          budget_s      = budget;
          idle_s        = idle_limit;
          txn_cnt_s     = REG_ZERO;
          idle_cnt_s    = REG_ZERO;
          grant_valid_s = 1'b1;
          busy_s        = 1'b1;
        end else begin
          state_s       = ST_IDLE;
          grant_valid_s = 1'b0;
          busy_s        = 1'b0;
        end
      end
      ST_GRANT: begin
        if (txn_done) begin
          txn_cnt_s  = txn_cnt_r + REG_ONE;
          idle_cnt_s = REG_ZERO;
        end else if (idle_cnt_r != REG_MAX) begin
          idle_cnt_s = idle_cnt_r + REG_ONE;
        end else begin
          idle_cnt_s = idle_cnt_r;
        end
        if (preempt) begin
          exit_code_s = 2'd3;
        end else if (budget_hit_s) begin
          exit_code_s = 2'd1;
        end else if (idle_hit_s) begin
          exit_code_s = 2'd2;
        end else begin
          exit_code_s = 2'd0;
        end
        if (exit_code_s != 2'd0) begin
          state_s       = ST_RELEASE;
          grant_valid_s = 1'b0;
          q_consumed_s  = 1'b1;
          exit_reason_s = exit_code_s;
        end else begin
          state_s       = ST_GRANT;
          grant_valid_s = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_s       = ST_IDLE;
        grant_valid_s = 1'b0;
        busy_s        = 1'b0;
        if (grants_issued_r != REG_MAX) begin
          grants_issued_s = grants_issued_r + REG_ONE;
        end else begin
          grants_issued_s = grants_issued_r;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        grant_valid_s = 1'b0;
        busy_s        = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_id_r      <= {DATA_SIZE{1'b0}};
      grant_valid_r   <= 1'b0;
      q_consumed_r    <= 1'b0;
      busy_r          <= 1'b0;
      exit_reason_r   <= 2'd0;
      grants_issued_r <= REG_ZERO;
      txn_cnt_r       <= REG_ZERO;
      idle_cnt_r      <= REG_ZERO;
      budget_r        <= REG_ZERO;
      idle_r          <= REG_ZERO;
    end else begin
      grant_id_r      <= grant_id_s;
      grant_valid_r   <= grant_valid_s;
      q_consumed_r    <= q_consumed_s;
      busy_r          <= busy_s;
      exit_reason_r   <= exit_reason_s;
      grants_issued_r <= grants_issued_s;
      txn_cnt_r       <= txn_cnt_s;
      idle_cnt_r      <= idle_cnt_s;
      budget_r        <= budget_s;
      idle_r          <= idle_s;
    end
  end

  assign grant_id      = grant_id_r;
  assign grant_valid   = grant_valid_r;
  assign q_consumed    = q_consumed_r;
  assign busy          = busy_r;
  assign exit_reason   = exit_reason_r;
  assign grants_issued = grants_issued_r;

endmodule
